// File: rtl/encoder_ctrl_pkg.sv
// Shared types, default sizes and saturating arithmetic for the encoder
// position/homing controller.
package encoder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOMED  = 2'd2,
        FAULT  = 2'd3
    } home_state_t;

    localparam int unsigned POS_WIDTH_DEF  = 32;
    localparam int unsigned VEL_WIDTH_DEF  = 16;
    localparam int unsigned VEL_WINDOW_DEF = 50000;
    localparam int unsigned SEARCH_MAX_DEF = 720;
    localparam int          HOME_OFFSET_DEF = 0;

    // Signed add clamped to the range of a 'width'-bit two's-complement value (width <= 32).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned width);
        logic signed [33:0] sum;
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        sum = 34'(a) + 34'(b);
        hi  = (34'sd1 <<< (width - 1)) - 34'sd1;
        lo  = -(34'sd1 <<< (width - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/encoder_velocity_meter.sv
// Free-running window counter with a saturating pulse accumulator; publishes
// the signed pulse count of each completed window with a one-cycle strobe.
module encoder_velocity_meter
    import encoder_ctrl_pkg::*;
#(
    parameter int unsigned VEL_WIDTH  = VEL_WIDTH_DEF,
    parameter int unsigned VEL_WINDOW = VEL_WINDOW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 count_pulse,
    input  logic                 direction,
    output logic [VEL_WIDTH-1:0] velocity,
    output logic                 vel_valid
);

    localparam int unsigned     WIN_W    = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);

    logic [WIN_W-1:0]            win_q, win_d;
    logic signed [VEL_WIDTH-1:0] acc_q, acc_d;
    logic signed [VEL_WIDTH-1:0] vel_q, vel_d;
    logic signed [VEL_WIDTH-1:0] acc_sum;
    logic signed [31:0]          delta;
    logic                        valid_q, valid_d;

    // The last cycle of a window folds its own pulse into the published value.
    always_comb begin
        delta   = count_pulse ? (direction ? 32'sd1 : -32'sd1) : 32'sd0;
        acc_sum = VEL_WIDTH'(sat_add(32'(acc_q), delta, VEL_WIDTH));
        win_d   = win_q + WIN_W'(1);
        acc_d   = acc_sum;
        vel_d   = vel_q;
        valid_d = 1'b0;
        if (win_q == WIN_LAST) begin
            win_d   = '0;
            acc_d   = '0;
            vel_d   = acc_sum;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q   <= '0;
            acc_q   <= '0;
            vel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
            valid_q <= valid_d;
        end
    end

    assign velocity  = vel_q;
    assign vel_valid = valid_q;

endmodule

// File: rtl/encoder_position_ctrl.sv
// Absolute position register with index-based homing sequencer and a
// windowed velocity measurement, driven by quadrature decoder strobes.
module encoder_position_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int unsigned POS_WIDTH   = POS_WIDTH_DEF,
    parameter int unsigned VEL_WIDTH   = VEL_WIDTH_DEF,
    parameter int unsigned VEL_WINDOW  = VEL_WINDOW_DEF,
    parameter int unsigned SEARCH_MAX  = SEARCH_MAX_DEF,
    parameter int          HOME_OFFSET = HOME_OFFSET_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 count_pulse,
    input  logic                 direction,
    input  logic                 index,
    input  logic                 cmd_home,
    input  logic                 cmd_clear,
    input  logic                 cmd_preset,
    input  logic [POS_WIDTH-1:0] preset_value,
    output logic [POS_WIDTH-1:0] position,
    output logic [VEL_WIDTH-1:0] velocity,
    output logic                 vel_valid,
    output logic                 homed,
    output logic                 home_fault,
    output logic                 wrapped,
    output logic [1:0]           state
);

    localparam int unsigned          CNT_W    = $clog2(SEARCH_MAX + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SEARCH_MAX - 1);
    localparam logic [POS_WIDTH-1:0] POS_MAX  = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic [POS_WIDTH-1:0] POS_MIN  = {1'b1, {(POS_WIDTH-1){1'b0}}};

    home_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 wrap_q, wrap_d;
    logic                 index_q;
    logic                 idx_rise;

    assign idx_rise = index & ~index_q;

    // Homing sequencer; cmd_clear overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HOMED, FAULT: begin
                if (cmd_home) begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            end
            SEARCH: begin
                if (idx_rise) begin
                    state_d = HOMED;
                end else if (cmd_home) begin
                    cnt_d = '0;
                end else if (count_pulse) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = FAULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cmd_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Position update: clear > index capture > preset > count.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = wrap_q;
        if (cmd_clear) begin
            pos_d  = '0;
            wrap_d = 1'b0;
        end else if ((state_q == SEARCH) && idx_rise) begin
            pos_d = POS_WIDTH'(HOME_OFFSET);
        end else if (cmd_preset) begin
            pos_d = preset_value;
        end else if (count_pulse) begin
            if (direction) begin
                pos_d = pos_q + POS_WIDTH'(1);
                if (pos_q == POS_MAX) wrap_d = 1'b1;
            end else begin
                pos_d = pos_q - POS_WIDTH'(1);
                if (pos_q == POS_MIN) wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            index_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            index_q <= index;
        end
    end

    encoder_velocity_meter #(
        .VEL_WIDTH  (VEL_WIDTH),
        .VEL_WINDOW (VEL_WINDOW)
    ) u_vel (
        .clk         (clk),
        .reset       (reset),
        .count_pulse (count_pulse),
        .direction   (direction),
        .velocity    (velocity),
        .vel_valid   (vel_valid)
    );

    assign position   = pos_q;
    assign wrapped    = wrap_q;
    assign state      = state_q;
    assign homed      = (state_q == HOMED);
    assign home_fault = (state_q == FAULT);

endmodule

// File: tb/tb_encoder_position_ctrl.sv
// Directed bench: reset, counting/wrap, homing/fault sequencing and velocity windows.
module tb_encoder_position_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       count_pulse;
    logic       direction;
    logic       index;
    logic       cmd_home;
    logic       cmd_clear;
    logic       cmd_preset;
    logic [7:0] preset_value;

    logic [7:0] position,  s_position;
    logic [7:0] velocity;
    logic [3:0] s_velocity;
    logic       vel_valid, homed, home_fault, wrapped;
    logic       s_vel_valid, s_homed, s_home_fault, s_wrapped;
    logic [1:0] state, s_state;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    encoder_position_ctrl #(
        .POS_WIDTH(8), .VEL_WIDTH(8), .VEL_WINDOW(10), .SEARCH_MAX(8), .HOME_OFFSET(100)
    ) dut (
        .clk(clk), .reset(reset), .count_pulse(count_pulse), .direction(direction),
        .index(index), .cmd_home(cmd_home), .cmd_clear(cmd_clear), .cmd_preset(cmd_preset),
        .preset_value(preset_value), .position(position), .velocity(velocity),
        .vel_valid(vel_valid), .homed(homed), .home_fault(home_fault), .wrapped(wrapped),
        .state(state)
    );

    // Narrow velocity output to exercise saturation; shares all inputs.
    encoder_position_ctrl #(
        .POS_WIDTH(8), .VEL_WIDTH(4), .VEL_WINDOW(10), .SEARCH_MAX(8), .HOME_OFFSET(100)
    ) dut_sat (
        .clk(clk), .reset(reset), .count_pulse(count_pulse), .direction(direction),
        .index(index), .cmd_home(cmd_home), .cmd_clear(cmd_clear), .cmd_preset(cmd_preset),
        .preset_value(preset_value), .position(s_position), .velocity(s_velocity),
        .vel_valid(s_vel_valid), .homed(s_homed), .home_fault(s_home_fault),
        .wrapped(s_wrapped), .state(s_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic dir);
        count_pulse = 1'b1;
        direction   = dir;
        tick();
        count_pulse = 1'b0;
    endtask

    task automatic pulses(input int n, input logic dir);
        repeat (n) pulse(dir);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns just after the edge on which vel_valid rises, so the next drive lands in window slot 0.
    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (vel_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s: vel_valid observed=0 expected=1 within 30 cycles", tag);
        end
    endtask

    initial begin
        reset = 1'b0; count_pulse = 1'b0; direction = 1'b0; index = 1'b0;
        cmd_home = 1'b0; cmd_clear = 1'b0; cmd_preset = 1'b0; preset_value = 8'd0;
        idle(2);
        reset = 1'b1;

        // Reset
        pulses(10, 1'b1);
        check("pre_reset_pos", position, 8'd10);
        reset = 1'b0; tick(); reset = 1'b1;
        check("rst_pos", position, 8'd0);
        check("rst_state", state, 2'd0);
        check("rst_vel", velocity, 8'd0);
        check("rst_vvalid", vel_valid, 1'b0);
        check("rst_homed", homed, 1'b0);
        check("rst_fault", home_fault, 1'b0);
        check("rst_wrapped", wrapped, 1'b0);
        check("rst_sat_vel", s_velocity, 4'd0);

        // Counting and wrap
        pulses(5, 1'b1);
        pulses(2, 1'b0);
        check("count_up_down", position, 8'd3);
        preset_value = 8'd127; cmd_preset = 1'b1; tick(); cmd_preset = 1'b0;
        check("preset_127", position, 8'h7F);
        check("no_wrap_yet", wrapped, 1'b0);
        pulse(1'b1);
        check("wrap_max_pos", position, 8'h80);
        check("wrap_max_flag", wrapped, 1'b1);
        pulse(1'b0);
        check("wrap_min_pos", position, 8'h7F);
        check("wrap_sticky", wrapped, 1'b1);
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        check("clear_pos", position, 8'd0);
        check("clear_wrapped", wrapped, 1'b0);

        // Homing with index capture
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        check("home_search", state, 2'd1);
        pulses(3, 1'b1);
        check("search_count", position, 8'd3);
        index = 1'b1; tick();
        check("capture_state", state, 2'd2);
        check("capture_homed", homed, 1'b1);
        check("capture_pos", position, 8'd100);
        pulses(2, 1'b1);
        check("no_recapture_pos", position, 8'd102);
        check("no_recapture_state", state, 2'd2);
        index = 1'b0; tick();

        // Search timeout
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        check("rehome_state", state, 2'd1);
        check("rehome_homed", homed, 1'b0);
        pulses(7, 1'b1);
        check("search_7", state, 2'd1);
        pulse(1'b1);
        check("fault_state", state, 2'd3);
        check("fault_flag", home_fault, 1'b1);
        check("fault_pos", position, 8'd110);
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        check("fault_to_search", state, 2'd1);
        check("fault_flag_clr", home_fault, 1'b0);

        // cmd_home in SEARCH restarts the pulse budget
        pulses(5, 1'b1);
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        pulses(7, 1'b1);
        check("restart_no_fault", state, 2'd1);
        pulse(1'b1);
        check("restart_fault", state, 2'd3);

        // Index coincident with the limit pulse: HOMED wins, capture beats count
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        pulses(7, 1'b1);
        index = 1'b1; pulse(1'b1);
        check("coincide_state", state, 2'd2);
        check("coincide_pos", position, 8'd100);
        index = 1'b0; tick();

        // cmd_clear overrides cmd_home
        cmd_home = 1'b1; tick(); cmd_home = 1'b0;
        check("pre_clear_search", state, 2'd1);
        cmd_clear = 1'b1; cmd_home = 1'b1; tick(); cmd_clear = 1'b0; cmd_home = 1'b0;
        check("clear_home_state", state, 2'd0);
        check("clear_home_pos", position, 8'd0);

        // Velocity: +4 window then -6 window
        wait_valid("sync_a");
        pulses(4, 1'b1);
        idle(5);
        check("vvalid_early", vel_valid, 1'b0);
        tick();
        check("vvalid_up", vel_valid, 1'b1);
        check("vel_up4", velocity, 8'd4);
        tick();
        check("vvalid_one_cycle", vel_valid, 1'b0);
        pulses(6, 1'b0);
        idle(3);
        check("vvalid_dn", vel_valid, 1'b1);
        check("vel_dn6", velocity, 8'hFA);

        // Preset and pulse together: position takes preset, window still counts the pulse
        wait_valid("sync_b");
        preset_value = 8'd50; cmd_preset = 1'b1; pulse(1'b1); cmd_preset = 1'b0;
        check("preset_beats_count", position, 8'd50);
        pulses(2, 1'b1);
        check("post_preset_count", position, 8'd52);
        idle(7);
        check("vvalid_preset", vel_valid, 1'b1);
        check("vel_preset_win", velocity, 8'd3);

        // Saturation on the 4-bit velocity instance
        wait_valid("sync_c");
        pulses(9, 1'b1);
        idle(1);
        check("sat_vvalid", s_vel_valid, 1'b1);
        check("sat_vel", s_velocity, 4'h7);
        check("wide_vel", velocity, 8'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
